// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the dmem port-0 arbiter.
// Imported by the arbiter top and its wait-counter sub-module.
package dmem_arb_pkg;

   localparam int DEF_AW       = 32;
   localparam int DEF_DW       = 32;
   localparam int DEF_MAX_WAIT = 8;
   localparam int WAIT_W       = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      LOCK1 = 1'b1
   } arb_state_t;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } arb_id_t;

   function automatic arb_id_t other_id(input arb_id_t id);
      return (id == M0) ? M1 : M0;
   endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating count of cycles a requester has been pending without a grant.
// Clears whenever the requester is granted or drops its request.
module arb_wait_ctr
   import dmem_arb_pkg::*;
#(
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic gnt,
   output logic at_max
);

   localparam logic [WAIT_W-1:0] MAX_V = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!req || gnt) begin
         count <= '0;
      end else if (count != MAX_V) begin
         count <= count + 1'b1;
      end
   end

   assign at_max = (count == MAX_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the read/write port of dmem: CPU load/store unit (m0) and DMA/loader (m1).
// Grant and mem mux are combinational from registered state; read data returns one cycle after grant.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_WAIT = DEF_MAX_WAIT,
   parameter int CPU_PRIO = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   input  logic          m1_lock,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   output logic          err_misalign,
   output arb_state_t    dbg_state
);

   // Handshake: a master raises req with we/addr/wdata stable and holds them until the
   // cycle its gnt is high; that cycle is the access. Reads return rvalid exactly one cycle later.

   arb_state_t state;
   arb_id_t    rr_ptr;
   logic       wait0_max;
   logic       wait1_max;
   logic       pick0;
   logic       pick1;

   arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (m0_req),
      .gnt    (m0_gnt),
      .at_max (wait0_max)
   );

   arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (m1_req),
      .gnt    (m1_gnt),
      .at_max (wait1_max)
   );

   // Conflict resolution only matters when both request; a lone requester always wins.
   always_comb begin
      pick0 = 1'b0;
      pick1 = 1'b0;
      if (m0_req && m1_req) begin
         if (state == LOCK1) begin
            pick0 = wait0_max;
            pick1 = !wait0_max;
         end else if (CPU_PRIO != 0) begin
            pick0 = !wait1_max;
            pick1 = wait1_max;
         end else begin
            pick0 = (rr_ptr == M0);
            pick1 = (rr_ptr == M1);
         end
      end else begin
         pick0 = m0_req;
         pick1 = m1_req;
      end
   end

   // Reset gates the grants so the port goes quiet the moment rst_n falls.
   assign m0_gnt = pick0 & rst_n;
   assign m1_gnt = pick1 & rst_n;

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      if (m0_gnt) begin
         mem_we   = m0_we;
         mem_addr = m0_addr;
         mem_wd   = m0_wdata;
      end else if (m1_gnt) begin
         mem_we   = m1_we;
         mem_addr = m1_addr;
         mem_wd   = m1_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= M0;
         err_misalign <= 1'b0;
      end else begin
         if (m0_gnt) begin
            rr_ptr <= other_id(M0);
         end else if (m1_gnt) begin
            rr_ptr <= other_id(M1);
         end
         if ((m0_gnt && (m0_addr[1:0] != 2'b00)) || (m1_gnt && (m1_addr[1:0] != 2'b00))) begin
            err_misalign <= 1'b1;
         end
         // Ownership is kept only by an m1 grant that still asks for the lock.
         case (state)
            IDLE: begin
               if (m1_gnt && m1_lock) begin
                  state <= LOCK1;
               end
            end
            LOCK1: begin
               if (!(m1_gnt && m1_lock)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_rvalid <= m0_gnt && !m0_we;
         m1_rvalid <= m1_gnt && !m1_we;
         if (m0_gnt && !m0_we) begin
            m0_rdata <= mem_rd;
         end
         if (m1_gnt && !m1_we) begin
            m1_rdata <= mem_rd;
         end
      end
   end

   assign dbg_state = state;

endmodule
